// File: rtl/tempsens_result_tx.sv
// tempsens_result_tx: serial result transmitter for the temperature-sensor tile.
// Accepts one 12-bit result per valid/ready handshake and sends it as a three-byte
// 8N1 UART packet, LSB first: HEADER, {4'h0, res[11:8]}, res[7:0].
// Results offered while a packet is in flight are counted in a saturating drop counter.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   res_data_i   12-bit measurement result, latched on the accept edge
//   res_valid_i  result available
//   res_ready_o  transmitter idle and able to accept (combinational)
//   tx_o         UART serial output, idles high (registered)
//   busy_o       packet in flight (== !res_ready_o)
//   drop_cnt_o   saturating count of cycles with a result offered while busy
//   drop_clr_i   synchronous clear of drop_cnt_o, wins over increment
module tempsens_result_tx #(
    parameter int unsigned CLK_DIV = 16,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] res_data_i,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o,
    input  logic        drop_clr_i
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);

    state_e      state_q;
    logic [15:0] bit_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [1:0]  byte_idx_q;
    logic [11:0] data_q;
    logic        tx_q;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        bit_end;
    logic [2:0]  bit_idx_nxt;
    logic [7:0]  cur_byte;

    assign bit_end     = (bit_cnt_q == BitLast);
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    always_comb begin
        cur_byte = data_q[7:0];
        unique case (byte_idx_q)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = {4'h0, data_q[11:8]};
            default: cur_byte = data_q[7:0];
        endcase
    end

    // tx_q is loaded with the bit of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (res_valid_i) begin
                        data_q     <= res_data_i;
                        state_q    <= StStart;
                        bit_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                        tx_q      <= cur_byte[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_nxt;
                            tx_q      <= cur_byte[bit_idx_nxt];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q == 2'd2) begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= StStart;
                            tx_q       <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign res_ready_o = (state_q == StIdle);
    assign busy_o      = ~res_ready_o;
    assign tx_o        = tx_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (res_valid_i && busy_o && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tempsens_result_tx.sv
// Bench for tempsens_result_tx. Three instances (CLK_DIV 4, 2, 16) share clock and reset.
// Expected line waveforms come from a packet-framing model; outputs are sampled on the
// falling edge, inputs are driven on the falling edge.
module tb_tempsens_result_tx;

    logic        clk;
    logic        rst_n;
    logic [11:0] data_r  [3];
    logic        valid_r [3];
    logic        clr_r   [3];
    logic        ready_w [3];
    logic        tx_w    [3];
    logic        busy_w  [3];
    logic [7:0]  drop_w  [3];

    int checks;
    int errors;

    tempsens_result_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .res_data_i(data_r[0]), .res_valid_i(valid_r[0]),
        .res_ready_o(ready_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]),
        .drop_cnt_o(drop_w[0]), .drop_clr_i(clr_r[0])
    );
    tempsens_result_tx #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .res_data_i(data_r[1]), .res_valid_i(valid_r[1]),
        .res_ready_o(ready_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]),
        .drop_cnt_o(drop_w[1]), .drop_clr_i(clr_r[1])
    );
    tempsens_result_tx dut16 (
        .clk(clk), .rst_n(rst_n), .res_data_i(data_r[2]), .res_valid_i(valid_r[2]),
        .res_ready_o(ready_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]),
        .drop_cnt_o(drop_w[2]), .drop_clr_i(clr_r[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 2 : 16;
    endfunction

    // Line level for each of the 30 bit slots of a packet carrying d.
    function automatic logic [29:0] frame(input logic [11:0] d);
        logic [7:0]  by [3];
        logic [29:0] f;
        by[0] = 8'hA5;
        by[1] = {4'h0, d[11:8]};
        by[2] = d[7:0];
        f = '0;
        for (int b = 0; b < 3; b++) begin
            f[b*10] = 1'b0;
            for (int i = 0; i < 8; i++) f[b*10+1+i] = by[b][i];
            f[b*10+9] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [23:0] decode(input logic [29:0] m);
        logic [23:0] r;
        r = '0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 8; i++) r[(2-b)*8+i] = m[b*10+1+i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one result on instance sel and follow the line cycle by cycle.
    // ovr: hold res_valid high for 300 busy cycles and exercise the drop counter.
    task automatic run_packet(input int sel, input logic [11:0] d, input bit ovr,
                              output logic [23:0] got);
        int          div;
        int          drops;
        logic [29:0] f;
        logic [29:0] mids;
        div   = div_of(sel);
        f     = frame(d);
        mids  = '0;
        drops = 0;
        @(negedge clk);
        check("ready_before", 32'(ready_w[sel]), 32'd1);
        valid_r[sel] = 1'b1;
        data_r[sel]  = d;
        @(negedge clk);
        valid_r[sel] = 1'b0;
        data_r[sel]  = 12'($urandom);
        for (int j = 0; j < 30 * div; j++) begin
            check("tx_bit", 32'(tx_w[sel]), 32'(f[j/div]));
            check("busy_ready", 32'({ready_w[sel], busy_w[sel]}), 32'b01);
            if (j % div == div / 2) mids[j/div] = tx_w[sel];
            if (ovr) begin
                if (j == 151 || j == 301) check("drop_count", 32'(drop_w[sel]), 32'(drops));
                if (j == 310) check("drop_hold", 32'(drop_w[sel]), 32'd255);
                if (j == 321) check("drop_clr", 32'(drop_w[sel]), 32'd0);
                if (j >= 1 && j <= 300) begin
                    valid_r[sel] = 1'b1;
                    data_r[sel]  = 12'($urandom);
                    if (drops < 255) drops++;
                end else if (j == 301) begin
                    valid_r[sel] = 1'b0;
                end
                if (j == 320) begin
                    valid_r[sel] = 1'b1;
                    clr_r[sel]   = 1'b1;
                end
                if (j == 321) begin
                    valid_r[sel] = 1'b0;
                    clr_r[sel]   = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("ready_rise", 32'({ready_w[sel], busy_w[sel], tx_w[sel]}), 32'b101);
        for (int b = 0; b < 3; b++) begin
            check("start_bit", 32'(mids[b*10]), 32'd0);
            check("stop_bit", 32'(mids[b*10+9]), 32'd1);
        end
        got = decode(mids);
    endtask

    logic [23:0] got;
    logic [11:0] rd;
    logic [29:0] f1, f2, m1, m2;
    logic        e;
    int          first;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            data_r[s]  = '0;
            valid_r[s] = 1'b0;
            clr_r[s]   = 1'b0;
        end

        // Reset and idle
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_tx", 32'(tx_w[s]), 32'd1);
            check("reset_ready", 32'({ready_w[s], busy_w[s]}), 32'b10);
            check("reset_drop", 32'(drop_w[s]), 32'd0);
        end
        for (int n = 0; n < 100; n++) begin
            check("idle_tx", 32'({tx_w[0], tx_w[1], tx_w[2]}), 32'b111);
            @(negedge clk);
        end

        // Single packet, CLK_DIV=4
        run_packet(0, 12'h3C7, 1'b0, got);
        check("single_bytes", 32'(got), 32'hA503C7);

        // Back-to-back with res_valid held high
        clr_r[0] = 1'b1;
        @(negedge clk);
        clr_r[0]   = 1'b0;
        valid_r[0] = 1'b1;
        data_r[0]  = 12'hFFF;
        @(negedge clk);
        data_r[0] = 12'h000;
        f1 = frame(12'hFFF);
        f2 = frame(12'h000);
        m1 = '0;
        m2 = '0;
        first = -1;
        for (int n = 0; n < 241; n++) begin
            if (n < 120) e = f1[n/4];
            else if (n == 120) e = 1'b1;
            else e = f2[(n-121)/4];
            check("b2b_tx", 32'(tx_w[0]), 32'(e));
            if (n >= 120 && first < 0 && tx_w[0] == 1'b0) first = n;
            if (n < 120 && n % 4 == 2) m1[n/4] = tx_w[0];
            if (n >= 121 && (n - 121) % 4 == 2) m2[(n-121)/4] = tx_w[0];
            if (n == 121) begin
                check("b2b_second_accept", 32'(ready_w[0]), 32'd0);
                check("b2b_drop", 32'(drop_w[0]), 32'd120);
                valid_r[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_ready_rise", 32'(ready_w[0]), 32'd1);
        check("b2b_spacing", 32'(first), 32'd121);
        check("b2b_bytes0", 32'(decode(m1)), 32'hA50FFF);
        check("b2b_bytes1", 32'(decode(m2)), 32'hA50000);

        // Overrun on the CLK_DIV=16 instance
        rd = 12'($urandom);
        run_packet(2, rd, 1'b1, got);
        check("ovr_bytes", 32'(got), 32'({8'hA5, 4'h0, rd}));

        // Reset mid-packet during byte1 data bits
        valid_r[0] = 1'b1;
        data_r[0]  = 12'($urandom);
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (61) @(negedge clk);
        check("pre_reset_tx", 32'(tx_w[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx_w[0]), 32'd1);
        check("async_reset_ready", 32'(ready_w[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'({ready_w[0], tx_w[0]}), 32'b11);
        run_packet(0, 12'h5A5, 1'b0, got);
        check("post_reset_bytes", 32'(got), 32'hA505A5);

        // Minimum divider
        run_packet(1, 12'h801, 1'b0, got);
        check("div2_bytes", 32'(got), 32'hA50801);

        // Randomized results on both fast instances
        for (int r = 0; r < 4; r++) begin
            rd = 12'($urandom);
            run_packet(r % 2, rd, 1'b0, got);
            check("rand_bytes", 32'(got), 32'({8'hA5, 4'h0, rd}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
